// File: rtl/syncgen_pkg.sv
// syncgen_pkg: shared timing types and defaults for the parametrised video
// timing generator.
//   axis_timing_t : active / front porch / sync width / back porch of one axis
//   axis_period() : total length of an axis (sum of the four fields)
//   VGA_H_TIMING / VGA_V_TIMING : the 640x480@60 reference raster
package syncgen_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned width;
    int unsigned back;
  } axis_timing_t;

  function automatic int unsigned axis_period(input axis_timing_t t);
    return t.active + t.front + t.width + t.back;
  endfunction

  localparam axis_timing_t VGA_H_TIMING = '{active: 640, front: 16, width: 96, back: 48};
  localparam axis_timing_t VGA_V_TIMING = '{active: 480, front: 10, width: 2,  back: 33};

endpackage

// File: rtl/syncgen_axis_cnt.sv
// syncgen_axis_cnt: one raster axis. A counter 0..PERIOD-1 that steps when
// adv_i is high, plus registered decodes of the counter's next value so the
// flags always describe the count visible in the same cycle.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   adv_i        : advance the counter this cycle
//   cnt_o        : current position
//   first_o      : position == 0
//   active_o     : position < ACTIVE
//   sync_o       : position in [SYNC_START, SYNC_END)
module syncgen_axis_cnt #(
  parameter int unsigned CW         = 11,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned PERIOD     = 800
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output logic          first_o,
  output logic          active_o,
  output logic          sync_o
);

  localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYN_BEG = CW'(SYNC_START);
  localparam logic [CW-1:0] SYN_END = CW'(SYNC_END);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          active_q, active_d;
  logic          sync_q, sync_d;

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
    // Decode the value the counter is about to hold, so flag and count
    // update on the same edge.
    first_d  = (cnt_d == '0);
    active_d = (cnt_d < ACT_END);
    sync_d   = (cnt_d >= SYN_BEG) && (cnt_d < SYN_END);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      first_q  <= 1'b1;
      active_q <= 1'b1;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign first_o  = first_q;
  assign active_o = active_q;
  assign sync_o   = sync_q;

endmodule

// File: rtl/syncgen_param.sv
// syncgen_param: parametrised raster timing generator (H/V counters, sync,
// display enable, line/frame start markers).
// Optional feature: define SYNCGEN_FRAME_CNT_EN to add the 16-bit FRAME_CNT
// output, which counts completed frames and wraps at 0xFFFF.
// Ports:
//   CLK, RST     : clock (pixel clock or faster system clock), async active-high reset
//   PCE          : pixel clock enable; everything holds while low
//   HCNT, VCNT   : current horizontal / vertical position
//   VGA_HS/VS    : sync outputs, active level set by HS_POL / VS_POL
//   DE           : inside the active area
//   LINE_START   : HCNT == 0
//   FRAME_START  : HCNT == 0 and VCNT == 0
//   FRAME_CNT    : frame counter (SYNCGEN_FRAME_CNT_EN only)
module syncgen_param
  import syncgen_pkg::*;
#(
  parameter int unsigned HACTIVE = VGA_H_TIMING.active,
  parameter int unsigned HFRONT  = VGA_H_TIMING.front,
  parameter int unsigned HWIDTH  = VGA_H_TIMING.width,
  parameter int unsigned HBACK   = VGA_H_TIMING.back,
  parameter int unsigned VACTIVE = VGA_V_TIMING.active,
  parameter int unsigned VFRONT  = VGA_V_TIMING.front,
  parameter int unsigned VWIDTH  = VGA_V_TIMING.width,
  parameter int unsigned VBACK   = VGA_V_TIMING.back,
  parameter logic        HS_POL  = 1'b0,
  parameter logic        VS_POL  = 1'b0,
  parameter int unsigned CW      = 11
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PCE,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          DE,
  output logic          LINE_START,
  output logic          FRAME_START
`ifdef SYNCGEN_FRAME_CNT_EN
  ,
  output logic [15:0]   FRAME_CNT
`endif
);

  localparam axis_timing_t H_T = '{active: HACTIVE, front: HFRONT, width: HWIDTH, back: HBACK};
  localparam axis_timing_t V_T = '{active: VACTIVE, front: VFRONT, width: VWIDTH, back: VBACK};
  localparam int unsigned HPERIOD     = axis_period(H_T);
  localparam int unsigned VPERIOD     = axis_period(V_T);
  localparam int unsigned HSYNC_START = HACTIVE + HFRONT;
  localparam int unsigned HSYNC_END   = HSYNC_START + HWIDTH;
  localparam int unsigned VSYNC_START = VACTIVE + VFRONT;
  localparam int unsigned VSYNC_END   = VSYNC_START + VWIDTH;

  // Geometry sanity: reject rasters the counters cannot represent.
  if (HACTIVE == 0 || HFRONT == 0 || HWIDTH == 0 || HBACK == 0 ||
      VACTIVE == 0 || VFRONT == 0 || VWIDTH == 0 || VBACK == 0) begin : g_err_zero
    $error("syncgen_param: geometry parameters must all be non-zero");
  end
  if (64'(HPERIOD) > (64'd1 << CW) || 64'(VPERIOD) > (64'd1 << CW)) begin : g_err_width
    $error("syncgen_param: HPERIOD/VPERIOD exceed the CW-bit counter range");
  end
  if (VSYNC_END >= VPERIOD) begin : g_err_vsync
    $error("syncgen_param: vertical sync must end before the last line");
  end

  localparam logic [CW-1:0] HLAST     = CW'(HPERIOD - 1);
  localparam logic [CW-1:0] HSYNC_PRE = CW'(HSYNC_START - 1);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_first, h_act, h_sync;
  logic          v_first, v_act, v_sync;
  logic          h_wrap;
  logic          vs_act_q, vs_act_d;

  // V steps on the same PCE cycle that H wraps.
  assign h_wrap = PCE && (h_cnt == HLAST);

  syncgen_axis_cnt #(
    .CW(CW), .ACTIVE(HACTIVE), .SYNC_START(HSYNC_START),
    .SYNC_END(HSYNC_END), .PERIOD(HPERIOD)
  ) u_h (
    .clk_i(CLK), .rst_i(RST), .adv_i(PCE),
    .cnt_o(h_cnt), .first_o(h_first), .active_o(h_act), .sync_o(h_sync)
  );

  syncgen_axis_cnt #(
    .CW(CW), .ACTIVE(VACTIVE), .SYNC_START(VSYNC_START),
    .SYNC_END(VSYNC_END), .PERIOD(VPERIOD)
  ) u_v (
    .clk_i(CLK), .rst_i(RST), .adv_i(h_wrap),
    .cnt_o(v_cnt), .first_o(v_first), .active_o(v_act), .sync_o(v_sync)
  );

  // VS only changes as HCNT steps onto the HS leading edge. On that edge V
  // cannot move (H is not wrapping), so v_sync already describes the line
  // being entered and can be sampled directly.
  always_comb begin
    vs_act_d = vs_act_q;
    if (PCE && (h_cnt == HSYNC_PRE)) begin
      vs_act_d = v_sync;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vs_act_q <= 1'b0;
    end else begin
      vs_act_q <= vs_act_d;
    end
  end

  assign HCNT        = h_cnt;
  assign VCNT        = v_cnt;
  assign VGA_HS      = h_sync   ? HS_POL : ~HS_POL;
  assign VGA_VS      = vs_act_q ? VS_POL : ~VS_POL;
  assign DE          = h_act & v_act;
  assign LINE_START  = h_first;
  assign FRAME_START = h_first & v_first;

`ifdef SYNCGEN_FRAME_CNT_EN
  localparam logic [CW-1:0] VLAST = CW'(VPERIOD - 1);

  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the cycle the raster returns to (0,0); wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (h_wrap && (v_cnt == VLAST)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_syncgen_param.sv
`timescale 1ns/1ps
module tb_syncgen_param;

  // Instance A: 640-pixel VGA line with a shortened frame (13 lines).
  localparam int A_HA = 640, A_HF = 16, A_HW = 96, A_HB = 48;
  localparam int A_VA = 6,   A_VF = 2,  A_VW = 2,  A_VB = 3;
  localparam int A_HP = 800, A_VP = 13;
  // Instance S: tiny raster, positive sync polarity, 4-bit counters.
  localparam int S_HA = 4, S_HF = 1, S_HW = 2, S_HB = 1;
  localparam int S_VA = 3, S_VF = 1, S_VW = 2, S_VB = 1;
  localparam int S_HP = 8, S_VP = 7;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pce_a = 1'b0;
  logic pce_s = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] hcnt_a, vcnt_a;
  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [3:0]  hcnt_s, vcnt_s;
  logic        hs_s, vs_s, de_s, ls_s, fs_s;
`ifdef SYNCGEN_FRAME_CNT_EN
  logic [15:0] fc_a, fc_s;
`endif

  syncgen_param #(
    .HACTIVE(A_HA), .HFRONT(A_HF), .HWIDTH(A_HW), .HBACK(A_HB),
    .VACTIVE(A_VA), .VFRONT(A_VF), .VWIDTH(A_VW), .VBACK(A_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) dut_a (
    .CLK(clk), .RST(rst), .PCE(pce_a), .HCNT(hcnt_a), .VCNT(vcnt_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .DE(de_a), .LINE_START(ls_a), .FRAME_START(fs_a)
`ifdef SYNCGEN_FRAME_CNT_EN
    , .FRAME_CNT(fc_a)
`endif
  );

  syncgen_param #(
    .HACTIVE(S_HA), .HFRONT(S_HF), .HWIDTH(S_HW), .HBACK(S_HB),
    .VACTIVE(S_VA), .VFRONT(S_VF), .VWIDTH(S_VW), .VBACK(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) dut_s (
    .CLK(clk), .RST(rst), .PCE(pce_s), .HCNT(hcnt_s), .VCNT(vcnt_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .DE(de_s), .LINE_START(ls_s), .FRAME_START(fs_s)
`ifdef SYNCGEN_FRAME_CNT_EN
    , .FRAME_CNT(fc_s)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference raster positions and frame counts.
  int          ma_h = 0, ma_v = 0, ms_h = 0, ms_v = 0;
  logic [15:0] ma_fc = '0, ms_fc = '0;
  obs_t        qa[$];
  obs_t        qs[$];

  function automatic obs_t model(input int h, input int v, input logic [15:0] fc,
                                 input int ha, input int hf, input int hw,
                                 input int va, input int vf, input int vw,
                                 input logic hpol, input logic vpol);
    obs_t o;
    int   hss, hse, vss, vse;
    bit   vs_on;
    hss = ha + hf; hse = hss + hw;
    vss = va + vf; vse = vss + vw;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hs = (h >= hss && h < hse) ? hpol : ~hpol;
    // VS spans from (line vss, pixel hss) up to (line vse, pixel hss).
    vs_on = (v > vss || (v == vss && h >= hss)) && (v < vse || (v == vse && h < hss));
    o.vs = vs_on ? vpol : ~vpol;
    o.de = (h < ha) && (v < va);
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.fc = fc;
    return o;
  endfunction

  task automatic adv_a();
    if (ma_h == A_HP - 1) begin
      ma_h = 0;
      if (ma_v == A_VP - 1) begin
        ma_v = 0;
`ifdef SYNCGEN_FRAME_CNT_EN
        ma_fc = ma_fc + 16'd1;
`endif
      end else ma_v = ma_v + 1;
    end else ma_h = ma_h + 1;
  endtask

  task automatic adv_s();
    if (ms_h == S_HP - 1) begin
      ms_h = 0;
      if (ms_v == S_VP - 1) begin
        ms_v = 0;
`ifdef SYNCGEN_FRAME_CNT_EN
        ms_fc = ms_fc + 16'd1;
`endif
      end else ms_v = ms_v + 1;
    end else ms_h = ms_h + 1;
  endtask

  function automatic obs_t sample_a();
    obs_t o;
    o = '{h: hcnt_a, v: vcnt_a, hs: hs_a, vs: vs_a, de: de_a, ls: ls_a, fs: fs_a, fc: 16'd0};
`ifdef SYNCGEN_FRAME_CNT_EN
    o.fc = fc_a;
`endif
    return o;
  endfunction

  function automatic obs_t sample_s();
    obs_t o;
    o = '{h: 11'(hcnt_s), v: 11'(vcnt_s), hs: hs_s, vs: vs_s, de: de_s, ls: ls_s, fs: fs_s, fc: 16'd0};
`ifdef SYNCGEN_FRAME_CNT_EN
    o.fc = fc_s;
`endif
    return o;
  endfunction

  // Called on a falling edge: sets PCE for the next rising edge, advances the
  // reference, queues the expected outputs, and returns on the next falling edge.
  task automatic drive(input logic pa, input logic ps);
    pce_a = pa;
    pce_s = ps;
    if (pa) adv_a();
    if (ps) adv_s();
    qa.push_back(model(ma_h, ma_v, ma_fc, A_HA, A_HF, A_HW, A_VA, A_VF, A_VW, 1'b0, 1'b0));
    qs.push_back(model(ms_h, ms_v, ms_fc, S_HA, S_HF, S_HW, S_VA, S_VF, S_VW, 1'b1, 1'b1));
    @(negedge clk);
  endtask

  localparam obs_t RST_A = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1, de: 1'b1, ls: 1'b1, fs: 1'b1, fc: 16'd0};
  localparam obs_t RST_S = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b0, de: 1'b1, ls: 1'b1, fs: 1'b1, fc: 16'd0};

  task automatic test_reset();
    obs_t got, exp;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    got = sample_a();
    if (got !== RST_A) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", got, RST_A); end
    n_tests++;
    got = sample_s();
    if (got !== RST_S) begin n_fail++; $display("FAIL reset_s got=%h exp=%h", got, RST_S); end
    rst = 1'b0;
    drive(1'b0, 1'b0);
    got = sample_a(); exp = qa.pop_front(); void'(qs.pop_front());
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
  endtask

  task automatic test_frame_a();
    obs_t got, exp;
    int   last_ls = 0, last_fs = 0, n_vs = 0;
    logic prev_vs;
    prev_vs = vs_a;
    for (int cyc = 1; cyc <= 2 * A_HP * A_VP; cyc++) begin
      drive(1'b1, 1'b0);
      got = sample_a(); exp = qa.pop_front(); void'(qs.pop_front());
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL frame_a cyc=%0d got=%h exp=%h", cyc, got, exp); end
      if (got.ls) begin
        n_tests++;
        if (cyc - last_ls !== A_HP) begin n_fail++; $display("FAIL hperiod got=%0d exp=%0d", cyc - last_ls, A_HP); end
        last_ls = cyc;
      end
      if (got.fs) begin
        n_tests++;
        if (cyc - last_fs !== A_HP * A_VP) begin n_fail++; $display("FAIL fs_period got=%0d exp=%0d", cyc - last_fs, A_HP * A_VP); end
        last_fs = cyc;
      end
      if (got.vs !== prev_vs) begin
        n_vs++;
        n_tests++;
        if (got.vs == 1'b0 && !(got.h == 11'd656 && got.v == 11'd8)) begin
          n_fail++; $display("FAIL vs_fall_pos got=(%0d,%0d) exp=(8,656)", got.v, got.h);
        end else if (got.vs == 1'b1 && !(got.h == 11'd656 && got.v == 11'd10)) begin
          n_fail++; $display("FAIL vs_rise_pos got=(%0d,%0d) exp=(10,656)", got.v, got.h);
        end
        prev_vs = got.vs;
      end
    end
    n_tests++;
    if (n_vs !== 4) begin n_fail++; $display("FAIL vs_edges got=%0d exp=4", n_vs); end
  endtask

  task automatic test_pce_div();
    obs_t got, exp;
    int   run = 0, n_runs = 0;
    bit   counting = 0;
    logic prev_ls;
    prev_ls = ls_a;
    for (int cyc = 0; cyc < 4 * A_HP * 3; cyc++) begin
      drive((cyc % 4) == 3, 1'b0);
      got = sample_a(); exp = qa.pop_front(); void'(qs.pop_front());
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL pce_div cyc=%0d got=%h exp=%h", cyc, got, exp); end
      if (got.ls && !prev_ls) begin counting = 1; run = 1; end
      else if (got.ls && counting) run++;
      else if (!got.ls && prev_ls && counting) begin
        n_runs++;
        n_tests++;
        if (run !== 4) begin n_fail++; $display("FAIL ls_width got=%0d exp=4", run); end
        counting = 0;
      end
      prev_ls = got.ls;
    end
    n_tests++;
    if (n_runs !== 2) begin n_fail++; $display("FAIL ls_runs got=%0d exp=2", n_runs); end
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    int   guard = 0;
    while (!(ma_h == 400 && ma_v == 3) && guard < 20000) begin
      drive(1'b1, 1'b0);
      got = sample_a(); exp = qa.pop_front(); void'(qs.pop_front());
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL pre_reset got=%h exp=%h", got, exp); end
      guard++;
    end
    n_tests++;
    if (guard >= 20000) begin n_fail++; $display("FAIL reach_400_3 got=timeout exp=position"); end
    pce_a = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    got = sample_a();
    if (got !== RST_A) begin n_fail++; $display("FAIL async_rst_a got=%h exp=%h", got, RST_A); end
    n_tests++;
    got = sample_s();
    if (got !== RST_S) begin n_fail++; $display("FAIL async_rst_s got=%h exp=%h", got, RST_S); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ma_h = 0; ma_v = 0; ma_fc = '0;
    ms_h = 0; ms_v = 0; ms_fc = '0;
    drive(1'b1, 1'b0);
    got = sample_a(); exp = qa.pop_front(); void'(qs.pop_front());
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL post_reset got=%h exp=%h", got, exp); end
    n_tests++;
    if (hcnt_a !== 11'd1 || vcnt_a !== 11'd0) begin
      n_fail++; $display("FAIL first_adv got=(%0d,%0d) exp=(0,1)", vcnt_a, hcnt_a);
    end
  endtask

  task automatic test_small();
    obs_t got, exp;
    int   last_ls = 0;
    for (int cyc = 1; cyc <= 3 * S_HP * S_VP; cyc++) begin
      drive(1'b0, 1'b1);
      got = sample_s(); exp = qs.pop_front(); void'(qa.pop_front());
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL small cyc=%0d got=%h exp=%h", cyc, got, exp); end
      if (got.ls) begin
        n_tests++;
        if (cyc - last_ls !== S_HP) begin n_fail++; $display("FAIL small_hperiod got=%0d exp=%0d", cyc - last_ls, S_HP); end
        last_ls = cyc;
      end
    end
`ifdef SYNCGEN_FRAME_CNT_EN
    n_tests++;
    if (fc_s !== 16'd3) begin n_fail++; $display("FAIL frame_cnt3 got=%0d exp=3", fc_s); end
`endif
  endtask

`ifdef SYNCGEN_FRAME_CNT_EN
  task automatic test_frame_cnt_wrap();
    obs_t got, exp;
    force dut_s.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_s.frame_cnt_q;
    ms_fc = 16'hFFFF;
    n_tests++;
    if (fc_s !== 16'hFFFF) begin n_fail++; $display("FAIL fc_preload got=%h exp=ffff", fc_s); end
    for (int cyc = 1; cyc <= S_HP * S_VP; cyc++) begin
      drive(1'b0, 1'b1);
      got = sample_s(); exp = qs.pop_front(); void'(qa.pop_front());
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL fc_wrap cyc=%0d got=%h exp=%h", cyc, got, exp); end
    end
    n_tests++;
    if (fc_s !== 16'h0000) begin n_fail++; $display("FAIL fc_wrap_zero got=%h exp=0000", fc_s); end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_a();
    test_pce_div();
    test_async_reset();
    test_small();
`ifdef SYNCGEN_FRAME_CNT_EN
    test_frame_cnt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
